// File: rtl/mux_nx1_stream_if.sv
// Handshake bundle between N producers, the N-to-1 stream mux and one consumer.
// The slave modport is the mux view; master is the surrounding producer/consumer side.
interface mux_nx1_stream_if #(
  parameter int W = 8,
  parameter int N = 8
) ();
  localparam int SELW = $clog2(N);

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_ch;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// N-to-1 streaming multiplexer: fixed-select or round-robin grant into a
// one-entry output register, valid/ready on both sides, one beat per cycle.
module mux_nx1_stream #(
  parameter  int W    = 8,
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  mux_nx1_stream_if.slave  bus
);

  logic [SELW-1:0] ptr_r;
  logic            out_valid_r;
  logic [W-1:0]    out_data_r;
  logic [SELW-1:0] out_ch_r;

  logic            load_en_s;
  logic            grant_valid_s;
  logic [SELW-1:0] grant_s;
  logic [N-1:0]    in_ready_s;
  logic            xfer_s;
  logic [W-1:0]    chan_data_s [N];
  int              idx_s;

  assign load_en_s = !out_valid_r || bus.out_ready;

  // Split the flat input bus into per-channel words.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      chan_data_s[k] = bus.in_data[k*W +: W];
    end
  end

  // Grant selection: explicit select or round-robin scan starting at ptr.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = {SELW{1'b0}};
    idx_s         = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N) begin
        grant_valid_s = 1'b1;
        grant_s       = sel;
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      // Descending loop so the channel nearest ptr is the last (winning) write.
      for (int i = N - 1; i >= 0; i--) begin
        idx_s = (int'(ptr_r) + i) % N;
        if (bus.in_valid[SELW'(idx_s)]) begin
          grant_valid_s = 1'b1;
          grant_s       = SELW'(idx_s);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  // Ready goes only to the granted channel, and never while in reset.
  always_comb begin
    in_ready_s = {N{1'b0}};
    if (rst_n && grant_valid_s) begin
      in_ready_s[grant_s] = load_en_s;
    end else begin
      in_ready_s = {N{1'b0}};
    end
  end

  assign xfer_s = grant_valid_s && bus.in_valid[grant_s] && in_ready_s[grant_s];

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_ch_r    <= {SELW{1'b0}};
      ptr_r       <= {SELW{1'b0}};
    end else begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= chan_data_s[grant_s];
        out_ch_r    <= grant_s;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (xfer_s && mode) begin
        ptr_r <= (int'(grant_s) == N - 1) ? {SELW{1'b0}} : grant_s + SELW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: an N=8 instance checked against a
// reference grant model with a beat scoreboard, plus an N=5 instance.
module tb_mux_nx1_stream;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode8, mode5;
  logic [2:0] sel8, sel5;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  int    m_ptr;
  logic  m_ov;

  mux_nx1_stream_if #(.W(8), .N(8)) bus8 ();
  mux_nx1_stream_if #(.W(8), .N(5)) bus5 ();

  mux_nx1_stream #(.W(8), .N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode8),
    .sel   (sel8),
    .bus   (bus8.slave)
  );

  mux_nx1_stream #(.W(8), .N(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode5),
    .sel   (sel5),
    .bus   (bus5.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of the N=8 instance: predict grant/ready, score the output
  // register, push the expected beat, then advance the model across the edge.
  task automatic step();
    logic [7:0] exp_rdy;
    logic       gv;
    int         g;
    logic       xfer;
    beat_t      b;
    @(negedge clk);
    gv = 1'b0;
    g  = 0;
    if (mode8 == 1'b0) begin
      gv = 1'b1;
      g  = int'(sel8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        int k;
        k = (m_ptr + i) % 8;
        if (!gv && bus8.in_valid[k]) begin
          gv = 1'b1;
          g  = k;
        end
      end
    end
    exp_rdy = 8'h00;
    if (rst_n && gv && (!m_ov || bus8.out_ready)) exp_rdy[g] = 1'b1;
    chk("in_ready", {24'h0, bus8.in_ready}, {24'h0, exp_rdy});
    chk("out_valid", {31'h0, bus8.out_valid}, {31'h0, m_ov});
    if (m_ov) begin
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed %0d queued expected >0", q.size());
      end
      if (q.size() > 0) begin
        chk("out_data", {24'h0, bus8.out_data}, {24'h0, q[0].data});
        chk("out_ch", {29'h0, bus8.out_ch}, {29'h0, q[0].ch});
        if (bus8.out_ready) void'(q.pop_front());
      end
    end
    xfer = rst_n && gv && bus8.in_valid[g] && exp_rdy[g];
    if (xfer) begin
      b.ch   = 3'(g);
      b.data = bus8.in_data[g*8 +: 8];
      q.push_back(b);
    end
    if (!rst_n) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      q.delete();
    end else begin
      if (xfer) m_ov = 1'b1;
      else if (m_ov && bus8.out_ready) m_ov = 1'b0;
      if (xfer && mode8) m_ptr = (g == 7) ? 0 : g + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_ptr = 0;
    m_ov  = 1'b0;
    rst_n = 1'b0;
    mode8 = 1'b1;
    sel8  = 3'd0;
    mode5 = 1'b1;
    sel5  = 3'd0;
    for (int k = 0; k < 8; k++) bus8.in_data[k*8 +: 8] = 8'(k * 17 + 3);
    for (int k = 0; k < 5; k++) bus5.in_data[k*8 +: 8] = 8'(8'hC0 + k);
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    bus5.in_valid  = 5'h1F;
    bus5.out_ready = 1'b1;

    // Reset held for three edges with every channel valid.
    repeat (3) begin
      step();
      chk("rst_in_ready5", {27'h0, bus5.in_ready}, 32'h0);
    end
    chk("rst_out_data8", {24'h0, bus8.out_data}, 32'h0);
    chk("rst_out_ch8", {29'h0, bus8.out_ch}, 32'h0);
    chk("rst_out_valid5", {31'h0, bus5.out_valid}, 32'h0);
    chk("rst_out_data5", {24'h0, bus5.out_data}, 32'h0);
    chk("rst_out_ch5", {29'h0, bus5.out_ch}, 32'h0);
    bus5.in_valid = 5'h00;
    rst_n = 1'b1;

    // Round-robin fairness: all valid, channels 0..7 then wrap to 0,1.
    repeat (10) step();

    // Fixed select on channel 5, then ready without valid.
    mode8 = 1'b0;
    sel8  = 3'd5;
    bus8.in_data[5*8 +: 8] = 8'hA5;
    bus8.in_valid = 8'h20;
    step();
    bus8.in_valid = 8'h00;
    repeat (2) step();

    // Round-robin skip: move ptr to 3, then channels 2 and 7 contend.
    mode8 = 1'b1;
    bus8.in_valid = 8'h04;
    step();
    bus8.in_valid = 8'h84;
    repeat (3) step();

    // Backpressure with a held beat, then back-to-back reload.
    bus8.out_ready = 1'b0;
    repeat (4) step();
    bus8.out_ready = 1'b1;
    repeat (3) step();

    // Reset while a beat is stalled in the register.
    bus8.out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus8.in_valid  = 8'hFF;
    bus8.out_ready = 1'b1;
    repeat (3) step();
    bus8.in_valid = 8'h00;
    repeat (2) step();
    chk("sb_drained", q.size(), 32'h0);

    // N=5 instance: out-of-range select, then top channel wraps ptr to 0.
    mode5 = 1'b0;
    sel5  = 3'd6;
    bus5.in_valid = 5'h1F;
    #1;
    chk("n5_sel6_ready", {27'h0, bus5.in_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("n5_sel6_valid", {31'h0, bus5.out_valid}, 32'h0);
    mode5 = 1'b1;
    bus5.in_valid = 5'h10;
    #1;
    chk("n5_rr_ready4", {27'h0, bus5.in_ready}, 32'h10);
    @(posedge clk);
    #1;
    chk("n5_rr_valid", {31'h0, bus5.out_valid}, 32'h1);
    chk("n5_rr_ch", {29'h0, bus5.out_ch}, 32'h4);
    chk("n5_rr_data", {24'h0, bus5.out_data}, 32'hC4);
    bus5.in_valid = 5'h11;
    #1;
    chk("n5_ptr_wrap_ready", {27'h0, bus5.in_ready}, 32'h01);
    @(posedge clk);
    #1;
    chk("n5_ptr_wrap_ch", {29'h0, bus5.out_ch}, 32'h0);
    chk("n5_ptr_wrap_data", {24'h0, bus5.out_data}, 32'hC0);
    bus5.in_valid = 5'h00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
